// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
//   Shared types and constants for the branch-predictor sequencing logic.
//   - bp_entry_t       : one in-flight branch (fetch PC, PHT index, predicted dir)
//   - resolve_state_t  : resolve controller state (RUN / RECOVER)
//   - DELAY_SLOT_OFFSET: fall-through distance past a MIPS branch + delay slot
//   - redirect_target(): fetch restart address after a mispredict
// -----------------------------------------------------------------------------
package bp_pkg;

  // Storage width of the PHT index inside a queued entry. The controller's
  // PHT_INDEX_BITS parameter must be set to this same value.
  localparam int PHT_INDEX_BITS_DEFAULT = 10;

  // A not-taken branch resumes after the branch and its delay slot.
  localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

  typedef struct packed {
    logic [31:0]                       pc;
    logic [PHT_INDEX_BITS_DEFAULT-1:0] idx;
    logic                              pred;
  } bp_entry_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } resolve_state_t;

  // Where fetch must restart once the real direction is known.
  // The pc + 8 sum is 32 bits wide, so it wraps modulo 2^32.
  function automatic logic [31:0] redirect_target(
    input logic        taken,
    input logic [31:0] target,
    input logic [31:0] pc
  );
    return taken ? target : (pc + DELAY_SLOT_OFFSET);
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// -----------------------------------------------------------------------------
// bp_inflight_fifo
//   In-order queue of branches that fetch has predicted and execute has not
//   yet resolved. Pointers carry one extra wrap bit so that full and empty can
//   be told apart without a separate counter.
//
// Ports
//   clk         in   clock
//   rst         in   synchronous reset, active-high (empties the queue)
//   push        in   write push_entry at the tail
//   push_entry  in   entry to write
//   pop         in   retire the head entry
//   clear       in   drop every entry; wins over push and pop
//   full        out  DEPTH entries held
//   empty       out  no entries held
//   head        out  oldest entry (only meaningful when !empty)
// -----------------------------------------------------------------------------
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  bp_entry_t push_entry,
  input  logic      pop,
  input  logic      clear,
  output logic      full,
  output logic      empty,
  output bp_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  bp_entry_t   mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: the entry array has no reset; an entry is only ever read after it
  // has been written, and leaving it unreset lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//   Sits between fetch, the global branch predictor and the hazard unit.
//   Every fetch-time prediction is queued; when execute resolves the oldest
//   branch, the controller trains the predictor and, on a mispredict, flushes
//   the younger work, redirects fetch and spends one RECOVER cycle ignoring
//   fetch/execute traffic while the queue restarts empty.
//
// Ports
//   clk              in   clock
//   rst              in   synchronous reset, active-high
//   push_validF      in   fetch issues a predicted branch
//   pcF              in   PC of that branch
//   PHT_indexF       in   PHT index from the predictor
//   predict_takeF    in   predicted direction
//   q_full           out  queue full or recovering; fetch must stall branches
//   resolve_validE   in   execute resolves the oldest in-flight branch
//   actual_takenE    in   resolved direction
//   branch_targetE   in   resolved taken target
//   branchE          out  one-cycle training pulse to the predictor
//   PHT_indexE       out  PHT index being trained
//   actually_takenE  out  resolved direction, aligned with branchE
//   predict_resultE  out  1 = prediction correct (idles high; low restores GHR)
//   flush_req        out  one-cycle flush of younger fetch/decode work
//   redirect_valid   out  one-cycle fetch redirect strobe
//   redirect_pc      out  fetch redirect address
//   err_underflow    out  sticky: a resolve arrived with an empty queue
// -----------------------------------------------------------------------------
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int PHT_INDEX_BITS = PHT_INDEX_BITS_DEFAULT,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_validF,
  input  logic [31:0]               pcF,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  input  logic                      predict_takeF,
  output logic                      q_full,
  input  logic                      resolve_validE,
  input  logic                      actual_takenE,
  input  logic [31:0]               branch_targetE,
  output logic                      branchE,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexE,
  output logic                      actually_takenE,
  output logic                      predict_resultE,
  output logic                      flush_req,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_pc,
  output logic                      err_underflow
);

  resolve_state_t state;

  logic      fifo_full;
  logic      fifo_empty;
  bp_entry_t head;
  bp_entry_t new_entry;

  logic resolve_fire;
  logic mispredict;
  logic pop_fire;
  logic push_fire;
  logic underflow;

  assign new_entry = '{pc: pcF, idx: PHT_indexF, pred: predict_takeF};

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    resolve_fire = 1'b0;
    mispredict   = 1'b0;
    pop_fire     = 1'b0;
    push_fire    = 1'b0;
    underflow    = 1'b0;
    if (state == RUN) begin
      resolve_fire = resolve_validE && !fifo_empty;
      underflow    = resolve_validE && fifo_empty;
      mispredict   = resolve_fire && (head.pred != actual_takenE);
      pop_fire     = resolve_fire && !mispredict;
      // A push alongside a mispredict is on the wrong path and is dropped.
      // A pop in the same cycle frees the slot, so push is legal at full.
      push_fire    = push_validF && (!fifo_full || pop_fire) && !mispredict;
    end
  end

  // Fetch is held off while recovering so it cannot queue into a queue that
  // is about to be (or has just been) emptied.
  assign q_full = fifo_full || (state == RECOVER);

  bp_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_fire),
    .push_entry (new_entry),
    .pop        (pop_fire),
    .clear      (mispredict),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      branchE         <= 1'b0;
      PHT_indexE      <= '0;
      actually_takenE <= 1'b0;
      predict_resultE <= 1'b1;
      flush_req       <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      err_underflow   <= 1'b0;
    end else begin
      branchE         <= resolve_fire;
      // Idles high: a low level tells the predictor to restore its GHR.
      predict_resultE <= resolve_fire ? !mispredict : 1'b1;
      flush_req       <= mispredict;
      redirect_valid  <= mispredict;

      if (resolve_fire) begin
        PHT_indexE      <= head.idx;
        actually_takenE <= actual_takenE;
      end

      if (mispredict) begin
        redirect_pc <= redirect_target(actual_takenE, branch_targetE, head.pc);
      end

      if (underflow) begin
        err_underflow <= 1'b1;
      end

      case (state)
        RUN:     state <= mispredict ? RECOVER : RUN;
        RECOVER: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//   Directed, table-driven bench for branch_resolve_ctrl (DEPTH=4, 10-bit
//   PHT index). Each table row is one clock cycle: the inputs driven before
//   the edge and the outputs expected just after it. A short hand-written
//   sequence covers reset asserted in the middle of recovery.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  localparam int W = 10;

  logic          clk;
  logic          rst;
  logic          push_validF;
  logic [31:0]   pcF;
  logic [W-1:0]  PHT_indexF;
  logic          predict_takeF;
  logic          q_full;
  logic          resolve_validE;
  logic          actual_takenE;
  logic [31:0]   branch_targetE;
  logic          branchE;
  logic [W-1:0]  PHT_indexE;
  logic          actually_takenE;
  logic          predict_resultE;
  logic          flush_req;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          err_underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_resolve_ctrl #(
    .PHT_INDEX_BITS (W),
    .DEPTH          (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .push_validF     (push_validF),
    .pcF             (pcF),
    .PHT_indexF      (PHT_indexF),
    .predict_takeF   (predict_takeF),
    .q_full          (q_full),
    .resolve_validE  (resolve_validE),
    .actual_takenE   (actual_takenE),
    .branch_targetE  (branch_targetE),
    .branchE         (branchE),
    .PHT_indexE      (PHT_indexE),
    .actually_takenE (actually_takenE),
    .predict_resultE (predict_resultE),
    .flush_req       (flush_req),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .err_underflow   (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    // stimulus
    logic         push;
    logic [31:0]  pc;
    logic [W-1:0] idx;
    logic         pred;
    logic         res;
    logic         act;
    logic [31:0]  tgt;
    // expected outputs after the edge
    logic         e_qf;
    logic         e_br;
    logic [W-1:0] e_idx;
    logic         e_at;
    logic         e_pr;
    logic         e_fl;
    logic         e_rv;
    logic [31:0]  e_rpc;
    logic         e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic push, input logic [31:0] pc, input logic [W-1:0] idx,
    input logic pred, input logic res, input logic act, input logic [31:0] tgt,
    input logic e_qf, input logic e_br, input logic [W-1:0] e_idx,
    input logic e_at, input logic e_pr, input logic e_fl, input logic e_rv,
    input logic [31:0] e_rpc, input logic e_err
  );
    vec_t v;
    v.push = push; v.pc = pc; v.idx = idx; v.pred = pred;
    v.res = res; v.act = act; v.tgt = tgt;
    v.e_qf = e_qf; v.e_br = e_br; v.e_idx = e_idx; v.e_at = e_at;
    v.e_pr = e_pr; v.e_fl = e_fl; v.e_rv = e_rv; v.e_rpc = e_rpc;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic push, input logic [31:0] pc,
                       input logic [W-1:0] idx, input logic pred,
                       input logic res, input logic act,
                       input logic [31:0] tgt);
    push_validF    = push;
    pcF            = pc;
    PHT_indexF     = idx;
    predict_takeF  = pred;
    resolve_validE = res;
    actual_takenE  = act;
    branch_targetE = tgt;
  endtask

  // One cycle: drive on the falling edge, sample 1 time unit after rising.
  task automatic cycle(input logic push, input logic [31:0] pc,
                       input logic [W-1:0] idx, input logic pred,
                       input logic res, input logic act,
                       input logic [31:0] tgt);
    @(negedge clk);
    drive(push, pc, idx, pred, res, act, tgt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 32'h0);

    // ---- reset: two cycles high --------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    check("reset predict_resultE", 32'(predict_resultE), 32'd1);
    check("reset branchE",         32'(branchE),         32'd0);
    check("reset q_full",          32'(q_full),          32'd0);
    check("reset err_underflow",   32'(err_underflow),   32'd0);
    check("reset flush_req",       32'(flush_req),       32'd0);
    check("reset redirect_valid",  32'(redirect_valid),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- vector table --------------------------------------------------------
    //               push pc            idx     pd res act tgt
    //               qf br e_idx  at pr fl rv rpc            err
    // Correct taken prediction.
    vecs.push_back(mk(1, 32'h0000_0100, 10'h03A, 1, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 1, 1, 32'h0,
                      0, 1, 10'h03A, 1, 1, 0, 0, 32'h0, 0));
    // Predicted taken, actually not taken: redirect to pc+8, then RECOVER.
    vecs.push_back(mk(1, 32'h0000_0200, 10'h055, 1, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 1, 0, 32'h0,
                      1, 1, 10'h055, 0, 0, 1, 1, 32'h0000_0208, 0));
    // RECOVER cycle: this push must be ignored.
    vecs.push_back(mk(1, 32'h0000_0300, 10'h1FF, 0, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 0));
    // Fill to DEPTH=4: full only after the 4th push (queue was empty).
    vecs.push_back(mk(1, 32'h0000_1000, 10'h001, 1, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'h0000_1004, 10'h002, 0, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'h0000_1008, 10'h003, 1, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'h0000_100C, 10'h004, 0, 0, 0, 32'h0,
                      1, 0, 10'h000, 0, 1, 0, 0, 32'h0, 0));
    // 5th push with no pop: dropped.
    vecs.push_back(mk(1, 32'h0000_1010, 10'h005, 1, 0, 0, 32'h0,
                      1, 0, 10'h000, 0, 1, 0, 0, 32'h0, 0));
    // Push + resolve at full: oldest (idx 1) retires, occupancy stays 4.
    vecs.push_back(mk(1, 32'h0000_1014, 10'h006, 1, 1, 1, 32'h0,
                      1, 1, 10'h001, 1, 1, 0, 0, 32'h0, 0));
    // Drain in order: idx 2, 3, 4, then 6 (the dropped idx 5 never appears).
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 1, 0, 32'h0,
                      0, 1, 10'h002, 0, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 1, 1, 32'h0,
                      0, 1, 10'h003, 1, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 1, 0, 32'h0,
                      0, 1, 10'h004, 0, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 1, 1, 32'h0,
                      0, 1, 10'h006, 1, 1, 0, 0, 32'h0, 0));
    // Resolve on an empty queue: sticky underflow, no training pulse.
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 1, 1, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 1));
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 1));
    // Not-taken -> taken mispredict with a simultaneous (wrong-path) push.
    vecs.push_back(mk(1, 32'h0000_0500, 10'h077, 0, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 1));
    vecs.push_back(mk(1, 32'h0000_0600, 10'h088, 1, 1, 1, 32'h0000_4000,
                      1, 1, 10'h077, 1, 0, 1, 1, 32'h0000_4000, 1));
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 1));
    // Queue must be empty: a resolve produces no training pulse.
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 1, 1, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 1));
    // pc + 8 wraps modulo 2^32.
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 10'h3FF, 1, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 1));
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 1, 0, 32'h0,
                      1, 1, 10'h3FF, 0, 0, 1, 1, 32'h0000_0004, 1));
    vecs.push_back(mk(0, 32'h0,         10'h000, 0, 0, 0, 32'h0,
                      0, 0, 10'h000, 0, 1, 0, 0, 32'h0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      cycle(v.push, v.pc, v.idx, v.pred, v.res, v.act, v.tgt);
      check($sformatf("v%0d q_full", i),          32'(q_full),          32'(v.e_qf));
      check($sformatf("v%0d branchE", i),         32'(branchE),         32'(v.e_br));
      check($sformatf("v%0d predict_resultE", i), 32'(predict_resultE), 32'(v.e_pr));
      check($sformatf("v%0d flush_req", i),       32'(flush_req),       32'(v.e_fl));
      check($sformatf("v%0d redirect_valid", i),  32'(redirect_valid),  32'(v.e_rv));
      check($sformatf("v%0d err_underflow", i),   32'(err_underflow),   32'(v.e_err));
      if (v.e_br) begin
        check($sformatf("v%0d PHT_indexE", i),      32'(PHT_indexE),      32'(v.e_idx));
        check($sformatf("v%0d actually_takenE", i), 32'(actually_takenE), 32'(v.e_at));
      end
      if (v.e_rv) begin
        check($sformatf("v%0d redirect_pc", i), redirect_pc, v.e_rpc);
      end
    end

    // ---- reset asserted during RECOVER ---------------------------------------
    cycle(1'b1, 32'h0000_0700, 10'h010, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("rr mispredict flush_req", 32'(flush_req), 32'd1);
    check("rr mispredict q_full",    32'(q_full),    32'd1);
    check("rr redirect_pc",          redirect_pc,    32'h0000_0708);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("rr after rst q_full",          32'(q_full),          32'd0);
    check("rr after rst err_underflow",   32'(err_underflow),   32'd0);
    check("rr after rst predict_resultE", 32'(predict_resultE), 32'd1);
    check("rr after rst flush_req",       32'(flush_req),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Back in RUN with an empty queue: a resolve underflows immediately.
    cycle(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b1, 32'h0);
    check("rr post branchE",       32'(branchE),       32'd0);
    check("rr post err_underflow", 32'(err_underflow), 32'd1);

    @(negedge clk);
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
